// File: rtl/aes_decrypt128.sv
// Iterative AES-128 inverse cipher: forward key expansion (one round key per clk),
// then ten inverse rounds (one per clk), with an optional last-key cache.

// GF(2^8) multiplicative inverse (poly 0x11b) computed as a^254; 0 maps to 0.
module gf_inv8 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] p, t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // r accumulates a^(2+4+...+128) = a^254
  function automatic logic [7:0] finv(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  assign y = finv(a);
endmodule

// Forward S-box: inverse then affine transform.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] v;
  gf_inv8 u_inv (.a(a), .y(v));
  assign y = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform then inverse.
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] u;
  assign u = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  gf_inv8 u_inv (.a(u), .y(y));
endmodule

module aes_decrypt128 #(
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, KEYEXP, ROUNDS, DONE} st_t;

  st_t          st, st_nxt;
  logic [3:0]   rnd;
  logic [127:0] ct, sreg, kexp, cache_key, knext;
  logic         cache_vld, hit;
  logic [127:0] rk [0:10];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // byte i = row (i%4), column (i/4); row r rotates right by r
  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a, x2, x4, x8;
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a  = s[127-8*(4*c+r) -: 8];
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        m9[r] = x8 ^ a;
        mb[r] = x8 ^ x2 ^ a;
        md[r] = x8 ^ x4 ^ a;
        me[r] = x8 ^ x4 ^ x2;
      end
      o[127-32*c -: 32] = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                           m9[0] ^ me[1] ^ mb[2] ^ md[3],
                           md[0] ^ m9[1] ^ me[2] ^ mb[3],
                           mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    end
    return o;
  endfunction

  // key schedule step
  logic [31:0] rotw, subw, kt, n0, n1, n2, n3;
  assign rotw = {kexp[23:0], kexp[31:24]};
  for (genvar j = 0; j < 4; j++) begin : g_sb
    sbox u_sb (.a(rotw[31-8*j -: 8]), .y(subw[31-8*j -: 8]));
  end
  assign kt    = subw ^ {rcon(rnd), 24'h0};
  assign n0    = kexp[127:96] ^ kt;
  assign n1    = kexp[95:64]  ^ n0;
  assign n2    = kexp[63:32]  ^ n1;
  assign n3    = kexp[31:0]   ^ n2;
  assign knext = {n0, n1, n2, n3};

  // inverse round
  logic [127:0] sh, sb, ark, rres;
  assign sh = inv_shift(sreg);
  for (genvar i = 0; i < 16; i++) begin : g_isb
    inv_sbox u_isb (.a(sh[127-8*i -: 8]), .y(sb[127-8*i -: 8]));
  end
  assign ark  = sb ^ rk[rnd];
  assign rres = (rnd == 4'd0) ? ark : inv_mix(ark);

  assign hit       = KEY_CACHE && cache_vld && (in_key == cache_key);
  assign in_ready  = (st == IDLE);
  assign out_valid = (st == DONE);
  assign busy      = (st == KEYEXP) || (st == ROUNDS);

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (in_valid) st_nxt = hit ? ROUNDS : KEYEXP;
      KEYEXP:  if (rnd == 4'd10) st_nxt = ROUNDS;
      ROUNDS:  if (rnd == 4'd0) st_nxt = DONE;
      DONE:    if (out_ready) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // rk[] is only trusted while cache_vld is set, so it needs no reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd       <= '0;
      out_data  <= '0;
      cache_vld <= 1'b0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          ct    <= in_data;
          kexp  <= in_key;
          rk[0] <= in_key;
          if (hit) begin
            sreg <= in_data ^ rk[10];
            rnd  <= 4'd9;
          end else begin
            rnd  <= 4'd1;
          end
        end
        KEYEXP: begin
          kexp    <= knext;
          rk[rnd] <= knext;
          if (rnd == 4'd10) begin
            sreg      <= ct ^ knext;
            cache_key <= rk[0];
            cache_vld <= KEY_CACHE;
            rnd       <= 4'd9;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        ROUNDS: begin
          sreg <= rres;
          if (rnd == 4'd0) out_data <= rres;
          else             rnd      <= rnd - 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decrypt128.sv
// Random and known-answer decrypt tests against a forward-cipher reference model;
// checks plaintext, latency (cache hit/miss), output hold, reset abort, busy input ignore.
module tb_aes_decrypt128;
  logic         clk = 1'b0;
  logic         rst;
  logic         iv0, iv1, out_ready;
  logic [127:0] in_data, in_key;
  logic         r0, ov0, bz0, r1, ov1, bz1;
  logic [127:0] od0, od1;

  aes_decrypt128 #(.KEY_CACHE(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(r0), .in_data(in_data), .in_key(in_key),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .busy(bz0));

  aes_decrypt128 #(.KEY_CACHE(1'b0)) u_dut_nc (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(r1), .in_data(in_data), .in_key(in_key),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .busy(bz1));

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  bit           sel;
  logic [7:0]   sbt [256];
  bit           mvld;
  logic [127:0] mkey;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic cur_rdy();  return sel ? r1  : r0;  endfunction
  function automatic logic cur_ov();   return sel ? ov1 : ov0; endfunction
  function automatic logic cur_bz();   return sel ? bz1 : bz0; endfunction
  function automatic logic [127:0] cur_od(); return sel ? od1 : od0; endfunction

  task automatic set_iv(input logic v);
    iv0 = v & ~sel;
    iv1 = v & sel;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box built by walking the multiplicative group with generator 3 and its inverse
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbt[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbt[0] = 8'h63;
  endtask

  // reference forward cipher; the DUT must invert it
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]], sbt[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbt[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rd < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic int exp_lat(input logic [127:0] k);
    if (!sel && mvld && k == mkey) return 10;
    return 20;
  endfunction

  // wait for ready, offer one block, count cycles to out_valid, optional stall, then handshake
  task automatic run_op(input logic [127:0] c, input logic [127:0] k, input int stall,
                        input bit garbage, output logic [127:0] pt, output int lat);
    int n;
    n = 0;
    while (!cur_rdy() && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("ready_timeout", 128'(cur_rdy()), 128'(1));
    in_data   = c;
    in_key    = k;
    out_ready = (stall == 0);
    set_iv(1'b1);
    @(negedge clk);
    set_iv(1'b0);
    lat = 0;
    while (!cur_ov() && lat < 100) begin
      if (garbage) begin
        in_data = {$urandom, $urandom, $urandom, $urandom};
        in_key  = {$urandom, $urandom, $urandom, $urandom};
        set_iv(lat % 3 == 1);
      end
      @(negedge clk);
      lat++;
      if (lat == 1) chk("busy", 128'(cur_bz()), 128'(1));
    end
    set_iv(1'b0);
    if (lat >= 100) chk("out_valid_timeout", 128'(cur_ov()), 128'(1));
    pt = cur_od();
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", 128'(cur_ov()), 128'(1));
      chk("hold_data", cur_od(), pt);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_valid", 128'(cur_ov()), 128'(0));
    chk("post_hs_ready", 128'(cur_rdy()), 128'(1));
    if (!sel) begin mvld = 1'b1; mkey = k; end
  endtask

  task automatic kat(input string tag, input logic [127:0] c, input logic [127:0] k,
                     input logic [127:0] exp_pt, input int stall, input bit garbage);
    logic [127:0] pt;
    int           el, lat;
    el = exp_lat(k);
    run_op(c, k, stall, garbage, pt, lat);
    chk({tag, "_pt"}, pt, exp_pt);
    chk({tag, "_lat"}, 128'(lat), 128'(el));
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C4 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k, p, c, pt;
    int           lat, el;
    build_sbox();
    sel = 1'b0; mvld = 1'b0; mkey = '0;
    rst = 1'b1; iv0 = 1'b0; iv1 = 1'b0; out_ready = 1'b1;
    in_data = '0; in_key = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(r0), 128'(1));
    chk("rst_out_valid", 128'(ov0), 128'(0));
    chk("rst_out_data", od0, '0);
    chk("rst_busy", 128'(bz0), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    chk("model_kat", aes_enc(P1, K1), C1);
    kat("fips_c1", C1, K1, P1, 0, 1'b0);
    kat("fips_b", C2, K2, P2, 0, 1'b0);
    kat("cached", C2, K2, P2, 0, 1'b0);
    sel = 1'b1;
    kat("nc_first", C2, K2, P2, 0, 1'b0);
    kat("nc_repeat", C2, K2, P2, 0, 1'b0);
    sel = 1'b0;
    kat("zero_key_stall", C4, '0, '0, 5, 1'b0);
    kat("pre_rst", C1, K1, P1, 0, 1'b0);

    // cached run of the same key, reset once it reaches rnd 5
    in_data = C1; in_key = K1; set_iv(1'b1);
    @(negedge clk);
    set_iv(1'b0);
    repeat (4) @(negedge clk);
    chk("mid_busy", 128'(bz0), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mvld = 1'b0;
    chk("abort_out_valid", 128'(ov0), 128'(0));
    chk("abort_in_ready", 128'(r0), 128'(1));
    chk("abort_busy", 128'(bz0), 128'(0));
    chk("abort_out_data", od0, '0);
    kat("after_rst", C1, K1, P1, 0, 1'b0);
    kat("garbage", C2, K2, P2, 0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      sel = (i % 4 == 3);
      if ($urandom_range(0, 2) == 0) k = sel ? K2 : mkey;
      else k = {$urandom, $urandom, $urandom, $urandom};
      p  = {$urandom, $urandom, $urandom, $urandom};
      c  = aes_enc(p, k);
      el = exp_lat(k);
      run_op(c, k, (i % 5 == 2) ? 2 : 0, (i % 6 == 1), pt, lat);
      chk($sformatf("rnd%0d_pt", i), pt, p);
      chk($sformatf("rnd%0d_lat", i), 128'(lat), 128'(el));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
